// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V decode types: immediate-format select codes,
//               default datapath width and base opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } imm_src_t;

    localparam int c_xlen_default = 32;

    // Base opcodes the control unit maps onto imm_src_t
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_system = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/imm_extend_comb.sv
// ============================================================================
// Module      : imm_extend_comb
// Description : Combinational immediate decode and sign/zero extension to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_comb
    import riscv_pkg::*;
#(
    parameter int XLEN = c_xlen_default
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic w_sign;
    logic w_unused_opcode;

    assign w_sign          = i_instr[31];
    // The opcode field never contributes to any immediate
    assign w_unused_opcode = ^i_instr[6:0];

    always_comb begin
        o_imm     = '0;
        o_illegal = 1'b0;
        case (imm_src_t'(i_imm_src))
            IMM_I: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
            IMM_S: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{(XLEN-12){w_sign}}, i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            IMM_J: o_imm = {{(XLEN-20){w_sign}}, i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            IMM_U: o_imm = {{(XLEN-31){w_sign}}, i_instr[30:12], 12'b0};
            IMM_Z: o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
            default: begin
                o_imm     = '0;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate generator with valid/ready and a
//               two-entry (main + skid) buffer for full-rate back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  w_imm;
    logic             w_illegal;
    logic             w_accept;
    logic             w_drain;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_illegal;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_illegal;
    logic             r_in_ready;

    imm_extend_comb #(
        .XLEN (XLEN)
    ) u_extend (
        .i_instr   (in_instr),
        .i_imm_src (in_imm_src),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid   <= 1'b0;
            r_main_imm     <= '0;
            r_main_tag     <= '0;
            r_main_illegal <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_tag     <= '0;
            r_skid_illegal <= 1'b0;
            r_in_ready     <= 1'b0;
        end else begin
            r_in_ready <= !r_skid_valid;
            if (w_drain) begin
                // in_ready is low whenever skid is full, so no accept competes here
                if (r_skid_valid) begin
                    r_main_imm     <= r_skid_imm;
                    r_main_tag     <= r_skid_tag;
                    r_main_illegal <= r_skid_illegal;
                    r_skid_valid   <= 1'b0;
                    r_in_ready     <= 1'b1;
                end else if (w_accept) begin
                    r_main_imm     <= w_imm;
                    r_main_tag     <= in_tag;
                    r_main_illegal <= w_illegal;
                end else begin
                    r_main_valid   <= 1'b0;
                end
            end else if (!r_main_valid) begin
                if (w_accept) begin
                    r_main_valid   <= 1'b1;
                    r_main_imm     <= w_imm;
                    r_main_tag     <= in_tag;
                    r_main_illegal <= w_illegal;
                end
            end else if (w_accept) begin
                r_skid_valid   <= 1'b1;
                r_skid_imm     <= w_imm;
                r_skid_tag     <= in_tag;
                r_skid_illegal <= w_illegal;
                r_in_ready     <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_imm     = r_main_imm;
    assign out_tag     = r_main_tag;
    assign out_illegal = r_main_illegal;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed self-checking bench for imm_gen_pipe at XLEN 32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32,  out_valid32,  out_illegal32;
    logic [31:0] out_imm32,   out_tag32;
    logic        in_ready64,  out_valid64,  out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .in_tag      (in_tag),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_tag     (out_tag32),
        .out_illegal (out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .in_tag      (in_tag),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (out_imm64),
        .out_tag     (out_tag64),
        .out_illegal (out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with out_ready=1 and check the registered result
    task automatic send32(input string name, input logic [31:0] instr,
                          input logic [2:0] src, input logic [31:0] tag,
                          input logic [31:0] exp_imm, input logic exp_ill);
        chk({name, "_in_ready"}, {63'b0, in_ready32}, 64'd1);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
        out_ready  = 1'b1;
        step();
        in_valid   = 1'b0;
        chk({name, "_valid"},   {63'b0, out_valid32},   64'd1);
        chk({name, "_imm"},     {32'b0, out_imm32},     {32'b0, exp_imm});
        chk({name, "_illegal"}, {63'b0, out_illegal32}, {63'b0, exp_ill});
        chk({name, "_tag"},     {32'b0, out_tag32},     {32'b0, tag});
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        step();
        chk("rst_out_valid", {63'b0, out_valid32},   64'd0);
        chk("rst_in_ready",  {63'b0, in_ready32},    64'd0);
        chk("rst_out_imm",   {32'b0, out_imm32},     64'd0);
        chk("rst_out_tag",   {32'b0, out_tag32},     64'd0);
        chk("rst_illegal",   {63'b0, out_illegal32}, 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {63'b0, in_ready32}, 64'd1);

        // Format decode at XLEN=32, each checked while the 64-bit copy tracks along
        send32("lw",  32'hFFC4A303, 3'b000, 32'h0000_1000, 32'hFFFF_FFFC, 1'b0);
        chk("lw_x64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        send32("sw",     32'h0064A423, 3'b001, 32'h0000_1004, 32'h0000_0008, 1'b0);
        send32("beq",    32'hFE420AE3, 3'b010, 32'h0000_1008, 32'hFFFF_FFF4, 1'b0);
        send32("jal",    32'h001000EF, 3'b011, 32'h0000_100C, 32'h0000_0800, 1'b0);
        send32("lui",    32'h12345037, 3'b100, 32'h0000_1010, 32'h1234_5000, 1'b0);
        send32("csrrwi", 32'hFFFFD073, 3'b101, 32'h0000_1014, 32'h0000_001F, 1'b0);
        send32("lui_neg", 32'h80000037, 3'b100, 32'h0000_1018, 32'h8000_0000, 1'b0);
        chk("lui_neg_x64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_neg_x64_tag", {32'b0, out_tag64}, 64'h0000_1018);
        send32("rsv110", 32'hFFFFFFFF, 3'b110, 32'hCAFE_0001, 32'h0000_0000, 1'b0 | 1'b1);
        chk("rsv110_x64", out_imm64, 64'd0);
        send32("rsv111", 32'h12345678, 3'b111, 32'hCAFE_0002, 32'h0000_0000, 1'b1);

        step();
        chk("idle_drained", {63'b0, out_valid32}, 64'd0);

        // Back-pressure stream: out_ready low for three edges
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'h00100093;
        in_imm_src = 3'b000;
        in_tag     = 32'd1;
        step();
        chk("bp_t1_valid",  {63'b0, out_valid32}, 64'd1);
        chk("bp_t1_tag",    {32'b0, out_tag32},   64'd1);
        chk("bp_ready_a",   {63'b0, in_ready32},  64'd1);
        in_tag = 32'd2;
        step();
        chk("bp_ready_low", {63'b0, in_ready32},  64'd0);
        chk("bp_hold_tag",  {32'b0, out_tag32},   64'd1);
        in_tag = 32'd3;
        step();
        chk("bp_ready_low2", {63'b0, in_ready32}, 64'd0);
        chk("bp_stable_tag", {32'b0, out_tag32},  64'd1);
        chk("bp_stable_imm", {32'b0, out_imm32},  64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out2",      {32'b0, out_tag32},   64'd2);
        chk("bp_ready_up",  {63'b0, in_ready32},  64'd1);
        step();
        chk("bp_out3",      {32'b0, out_tag32},   64'd3);
        chk("bp_out3_v",    {63'b0, out_valid32}, 64'd1);
        in_tag = 32'd4;
        step();
        in_valid = 1'b0;
        chk("bp_out4",      {32'b0, out_tag32},   64'd4);
        chk("bp_out4_v",    {63'b0, out_valid32}, 64'd1);
        step();
        chk("bp_empty",     {63'b0, out_valid32}, 64'd0);

        // Fill both entries, then reset mid-stream
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_tag     = 32'hA;
        step();
        in_tag     = 32'hB;
        step();
        in_valid   = 1'b0;
        chk("full_ready_low", {63'b0, in_ready32}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid",  {63'b0, out_valid32}, 64'd0);
        chk("mid_rst_ready",  {63'b0, in_ready32},  64'd0);
        chk("mid_rst_tag",    {32'b0, out_tag32},   64'd0);
        step();
        chk("after_rst_ready", {63'b0, in_ready32},  64'd1);
        chk("after_rst_valid", {63'b0, out_valid32}, 64'd0);
        send32("fresh", 32'h00A00513, 3'b000, 32'hC, 32'h0000_000A, 1'b0);
        step();
        chk("no_stale_valid", {63'b0, out_valid32}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the RISC-V core.
- Covers every RV32I/RV64I immediate format plus the CSR zimm field.
- Sign- or zero-extends to XLEN.
- Carries a sideband tag (typically the PC) and sits between fetch and execute.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains one instruction per cycle under back-pressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the pass-through sideband tag.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents an instruction.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  raw instruction word.
in_imm_src  input  3  immediate format select.
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag matching out_imm.
out_illegal  output  1  in_imm_src was a reserved code.

Behaviour:
- Format encoding (i = in_instr, s = sign bit i[31] replicated to fill XLEN):
  - 000 I: s, i[31:20].
  - 001 S: s, i[31:25], i[11:7].
  - 010 B: s, i[7], i[30:25], i[11:8], 0.
  - 011 J: s, i[19:12], i[20], i[30:21], 0.
  - 100 U: s, i[31:12], twelve zeros (sign-extended above bit 31 when XLEN=64).
  - 101 Z: zero-extended i[19:15].
  - 110/111 reserved: imm = 0, illegal = 1.
- Extension is combinational on the input side; the result is captured into the output register on handshake. No arithmetic beyond concatenation/replication.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is exactly 1 cycle from accept to out_valid when the buffer is empty.
- Storage is a main register (drives the outputs) and a skid register.
- in_ready is registered and equals !skid_valid.
- Accept with main empty, or main draining this cycle with skid empty: write main.
- Accept while main is full and not draining: write skid; in_ready falls next cycle.
- Main drains while skid is full: skid moves to main, skid clears, in_ready rises next cycle.
- Accept and drain in the same cycle: no bubble; throughput is 1/cycle.
- Order is strictly preserved. No entry is dropped or duplicated.
- out_* are stable while out_valid && !out_ready.
- Reset:
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - Skid cleared; in_ready=0 during the rst cycle, 1 on the first cycle after.
  - Reset mid-stream discards both entries silently; no partial output.
- in_* are ignored when !in_valid. Changes in out_ready while out_valid=0 have no effect.
- An XLEN value other than 32 or 64 is an elaboration error.

Decomposition:
- Shared package riscv_pkg holds:
  - enum imm_src_t {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z}, 3 bits.
  - XLEN default constant.
  - Opcode constants used by the control unit that drives imm_src.
- Natural sub-module imm_extend_comb: pure combinational format decode/extension, parametrised on XLEN. It is reusable by the single-cycle datapath.
- imm_gen_pipe instantiates imm_extend_comb and adds the skid-buffer control.

Test Plan:
- XLEN=32, lw 0xFFC4A303 src=000, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, illegal=0. sw 0x0064A423 src=001 -> 0x00000008.
- beq 0xFE420AE3 src=010 -> 0xFFFFFFF4. jal 0x001000EF src=011 -> 0x00000800. lui 0x12345037 src=100 -> 0x12345000. csrrwi with i[19:15]=0x1F, src=101 -> 0x0000001F.
- XLEN=64, 0x80000037 src=100 -> 0xFFFFFFFF80000000. 0xFFC4A303 src=000 -> 0xFFFFFFFFFFFFFFFC.
- Stream tags 1,2,3,4 back-to-back with out_ready=0 for 3 cycles:
  - Tags 1 and 2 accepted; in_ready=0 from cycle after second accept.
  - Release -> outputs 1,2,3,4 in order, one per cycle, no bubble, none lost.
- src=110 and 111 on any instr -> out_imm=0, out_illegal=1, tag passed through.
- Assert rst for 1 cycle with both entries full -> out_valid=0 the following cycle, in_ready=1 the cycle after rst deasserts, stale tags never appear.
